// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the
// decoder, datapath and memory ports.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             dec_reg_write;
  logic             dec_mem_write;
  logic             branch_taken;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             ir_write;
  logic             dmem_req;
  logic             dmem_we;
  logic             alu_out_we;
  logic             rf_we;
  logic             pc_write;
  logic             pc_src;
  logic [2:0]       state;
  logic             halted;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] retired;

  // The sequencer drives the strobes and the status outputs.
  modport master (
    input  opcode, dec_reg_write, dec_mem_write, branch_taken, imem_ack, dmem_ack,
    output imem_req, ir_write, dmem_req, dmem_we, alu_out_we, rf_we, pc_write,
           pc_src, state, halted, trap, trap_cause, retired
  );

  modport slave (
    output opcode, dec_reg_write, dec_mem_write, branch_taken, imem_ack, dmem_ack,
    input  imem_req, ir_write, dmem_req, dmem_we, alu_out_we, rf_we, pc_write,
           pc_src, state, halted, trap, trap_cause, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle RV32I controller: steps FETCH/DECODE/EXEC/MEM/WB, gates the
// decoder's write enables by phase, and reports halt/trap/retired status.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_sequencer_if.master bus
);
  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             timeout_hit;

  logic is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, is_op, is_opimm, is_system, is_legal;

  logic imem_req, ir_write, dmem_req, dmem_we, alu_out_we, rf_we, pc_write, pc_src;

  assign is_load   = (bus.opcode == 7'b0000011);
  assign is_store  = (bus.opcode == 7'b0100011);
  assign is_branch = (bus.opcode == 7'b1100011);
  assign is_jal    = (bus.opcode == 7'b1101111);
  assign is_jalr   = (bus.opcode == 7'b1100111);
  assign is_lui    = (bus.opcode == 7'b0110111);
  assign is_auipc  = (bus.opcode == 7'b0010111);
  assign is_op     = (bus.opcode == 7'b0110011);
  assign is_opimm  = (bus.opcode == 7'b0010011);
  assign is_system = (bus.opcode == 7'b1110011);
  assign is_legal  = is_load | is_store | is_branch | is_jal | is_jalr | is_lui |
                     is_auipc | is_op | is_opimm | is_system;

  // Saturating wait counter; the trap fires on the cycle it would reach the limit.
  assign cnt_inc     = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TO_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_out_we = 1'b0;
    rf_we      = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_write = 1'b1;
          cnt_d    = '0;
          state_d  = S_DECODE;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd2;
          end
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else if (is_system) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_out_we = 1'b1;
        cnt_d      = '0;
        if (is_branch) begin
          pc_write  = 1'b1;
          pc_src    = bus.branch_taken;
          retired_d = retired_q + 1'b1;
          state_d   = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.dec_mem_write & is_store;
        if (bus.dmem_ack) begin
          cnt_d = '0;
          if (is_store) begin
            pc_write  = 1'b1;
            retired_d = retired_q + 1'b1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd3;
          end
        end
      end
      S_WB: begin
        rf_we     = bus.dec_reg_write;
        pc_write  = 1'b1;
        pc_src    = is_jal | is_jalr;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_write   = ir_write;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.alu_out_we = alu_out_we;
  assign bus.rf_we      = rf_we;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.state      = state_q;
  assign bus.halted     = halted_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: inputs change on the falling edge,
// outputs are checked 1 time unit later.
module tb_multicycle_sequencer;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_ILL   = 7'b0001011;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  multicycle_sequencer_if #(.CNT_W(32)) bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an instruction with an immediate fetch ack, step through DECODE,
  // and return 1 unit after the edge that leaves DECODE.
  task automatic fetch_dec(input logic [6:0] op, input logic rw, input logic mw);
    bus.opcode        = op;
    bus.dec_reg_write = rw;
    bus.dec_mem_write = mw;
    bus.imem_ack      = 1'b1;
    #1;
    chk("fetch_state", 32'(bus.state), 0);
    chk("fetch_irw", 32'(bus.ir_write), 1);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    chk("dec_state", 32'(bus.state), 1);
    chk("dec_imem_req", 32'(bus.imem_req), 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.opcode        = '0;
    bus.dec_reg_write = 1'b0;
    bus.dec_mem_write = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.dmem_ack      = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_retired", bus.retired, 0);
    chk("rst_trap", 32'(bus.trap), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_cause", 32'(bus.trap_cause), 0);
    chk("rst_dmem_req", 32'(bus.dmem_req), 0);
    chk("rst_imem_req", 32'(bus.imem_req), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // OP-IMM: 0,1,2,4,0
    fetch_dec(OP_IMM, 1'b1, 1'b0);
    chk("opi_exec", 32'(bus.state), 2);
    chk("opi_alu_we", 32'(bus.alu_out_we), 1);
    chk("opi_exec_rf_we", 32'(bus.rf_we), 0);
    chk("opi_exec_pcw", 32'(bus.pc_write), 0);
    @(negedge clk); #1;
    chk("opi_wb", 32'(bus.state), 4);
    chk("opi_wb_rf_we", 32'(bus.rf_we), 1);
    chk("opi_wb_pcw", 32'(bus.pc_write), 1);
    chk("opi_wb_pcsrc", 32'(bus.pc_src), 0);
    @(negedge clk); #1;
    chk("opi_done", 32'(bus.state), 0);
    chk("opi_retired", bus.retired, 1);

    // LOAD, dmem_ack on the 4th MEM cycle
    fetch_dec(OP_LOAD, 1'b1, 1'b0);
    chk("ld_exec", 32'(bus.state), 2);
    @(negedge clk); #1;
    chk("ld_mem1", 32'(bus.state), 3);
    chk("ld_req1", 32'(bus.dmem_req), 1);
    chk("ld_we1", 32'(bus.dmem_we), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("ld_req_wait", 32'(bus.dmem_req), 1);
    end
    @(negedge clk);
    bus.dmem_ack = 1'b1;
    #1;
    chk("ld_req4", 32'(bus.dmem_req), 1);
    chk("ld_mem4_rf_we", 32'(bus.rf_we), 0);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    chk("ld_wb", 32'(bus.state), 4);
    chk("ld_wb_rf_we", 32'(bus.rf_we), 1);
    chk("ld_wb_req", 32'(bus.dmem_req), 0);
    @(negedge clk); #1;
    chk("ld_retired", bus.retired, 2);

    // BRANCH taken then not taken
    fetch_dec(OP_BR, 1'b0, 1'b0);
    bus.branch_taken = 1'b1;
    #1;
    chk("brt_exec", 32'(bus.state), 2);
    chk("brt_pcw", 32'(bus.pc_write), 1);
    chk("brt_pcsrc", 32'(bus.pc_src), 1);
    chk("brt_rf_we", 32'(bus.rf_we), 0);
    @(negedge clk);
    bus.branch_taken = 1'b0;
    #1;
    chk("brt_fetch", 32'(bus.state), 0);
    chk("brt_retired", bus.retired, 3);
    fetch_dec(OP_BR, 1'b0, 1'b0);
    chk("brn_pcw", 32'(bus.pc_write), 1);
    chk("brn_pcsrc", 32'(bus.pc_src), 0);
    @(negedge clk); #1;
    chk("brn_fetch", 32'(bus.state), 0);
    chk("brn_retired", bus.retired, 4);

    // STORE with ack exactly on MEM cycle 16
    fetch_dec(OP_STORE, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("st_mem1", 32'(bus.state), 3);
    chk("st_we1", 32'(bus.dmem_we), 1);
    repeat (14) @(negedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b1;
    #1;
    chk("st16_state", 32'(bus.state), 3);
    chk("st16_pcw", 32'(bus.pc_write), 1);
    chk("st16_pcsrc", 32'(bus.pc_src), 0);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
    chk("st16_done", 32'(bus.state), 0);
    chk("st16_trap", 32'(bus.trap), 0);
    chk("st16_retired", bus.retired, 5);

    // JAL writes back and selects the target
    fetch_dec(OP_JAL, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("jal_wb", 32'(bus.state), 4);
    chk("jal_pcsrc", 32'(bus.pc_src), 1);
    chk("jal_rf_we", 32'(bus.rf_we), 1);
    @(negedge clk); #1;
    chk("jal_retired", bus.retired, 6);

    // Illegal opcode traps; later fetch acks are ignored
    fetch_dec(OP_ILL, 1'b1, 1'b0);
    chk("ill_state", 32'(bus.state), 6);
    chk("ill_trap", 32'(bus.trap), 1);
    chk("ill_cause", 32'(bus.trap_cause), 1);
    bus.imem_ack = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("ill_stay", 32'(bus.state), 6);
    chk("ill_irw", 32'(bus.ir_write), 0);
    chk("ill_retired", bus.retired, 6);
    bus.imem_ack = 1'b0;

    rst_n = 1'b0;
    #1;
    chk("rst2_state", 32'(bus.state), 0);
    chk("rst2_trap", 32'(bus.trap), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // STORE with no data ack times out
    fetch_dec(OP_STORE, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("sto_mem1", 32'(bus.state), 3);
    repeat (15) @(negedge clk);
    #1;
    chk("sto_mem16", 32'(bus.state), 3);
    chk("sto_req16", 32'(bus.dmem_req), 1);
    @(negedge clk); #1;
    chk("sto_trap_state", 32'(bus.state), 6);
    chk("sto_trap", 32'(bus.trap), 1);
    chk("sto_cause", 32'(bus.trap_cause), 3);
    chk("sto_req_off", 32'(bus.dmem_req), 0);

    rst_n = 1'b0;
    #1;
    chk("rst3_cause", 32'(bus.trap_cause), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // SYSTEM halts
    fetch_dec(OP_SYS, 1'b0, 1'b0);
    chk("sys_state", 32'(bus.state), 5);
    chk("sys_halted", 32'(bus.halted), 1);
    chk("sys_trap", 32'(bus.trap), 0);
    @(negedge clk); #1;
    chk("sys_stay", 32'(bus.state), 5);

    rst_n = 1'b0;
    #1;
    chk("rst4_halted", 32'(bus.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // One LUI, then reset in the middle of a store
    fetch_dec(OP_LUI, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    chk("lui_retired", bus.retired, 1);
    fetch_dec(OP_STORE, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("mid_mem", 32'(bus.state), 3);
    chk("mid_we", 32'(bus.dmem_we), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.state), 0);
    chk("mid_rst_req", 32'(bus.dmem_req), 0);
    chk("mid_rst_we", 32'(bus.dmem_we), 0);
    chk("mid_rst_retired", bus.retired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_imem_req", 32'(bus.imem_req), 1);

    // Fetch timeout: no instruction ack for 16 cycles
    repeat (15) @(negedge clk);
    #1;
    chk("fto_cyc16", 32'(bus.state), 0);
    @(negedge clk); #1;
    chk("fto_state", 32'(bus.state), 6);
    chk("fto_cause", 32'(bus.trap_cause), 2);
    chk("fto_imem_req", 32'(bus.imem_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Control FSM that turns the existing combinational RV32I decoder into a multicycle core controller. It steps each instruction through fetch, decode, execute, memory and write-back phases. It drives instruction-memory and data-memory request/ack handshakes and gates the decoder's write enables so each one fires only in the correct phase. It sits between the instruction register/decoder and the PC, register file and memory ports, and also reports halt, trap and retired-instruction status.

Parameters:
MEM_TIMEOUT, 16, maximum cycles a memory request may wait for ack before trapping; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  opcode field of the instruction register (valid from DECODE onward)
dec_reg_write  in  1  decoder register-write request
dec_mem_write  in  1  decoder store indication
branch_taken  in  1  branch comparator result, valid in EXEC
imem_ack  in  1  instruction memory ack; instruction is valid on the same cycle
dmem_ack  in  1  data memory ack
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write strobe
alu_out_we  out  1  latch ALU result register
rf_we  out  1  register file write enable
pc_write  out  1  PC update enable
pc_src  out  1  0 = PC+4, 1 = ALU/branch target
state  out  3  current state encoding
halted  out  1  sticky: SYSTEM opcode reached
trap  out  1  sticky: error stop
trap_cause  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout
retired  out  CNT_W  count of completed instructions

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Reset (asynchronous): state=FETCH; halted=0, trap=0, trap_cause=0, retired=0, timeout counter=0.
- All strobes are Moore/Mealy combinational decodes of state plus inputs. Every strobe is 0 in any state not listed below.
- Opcode classes (all require opcode[1:0]=11):
  - LOAD 0000011; STORE 0100011; BRANCH 1100011; JAL 1101111; JALR 1100111.
  - LUI 0110111; AUIPC 0010111; OP 0110011; OP-IMM 0010011.
  - SYSTEM 1110011.
  - Any other opcode is illegal.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_write=1 in the same cycle, go to DECODE, clear the timeout counter.
  - Otherwise increment the timeout counter. When it reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0): go to TRAP, trap_cause=2.
  - If ack arrives on the same cycle the timeout is reached, ack wins.
- DECODE (1 cycle):
  - Illegal opcode → TRAP, trap_cause=1.
  - SYSTEM → HALT.
  - Otherwise → EXEC.
- EXEC (1 cycle), alu_out_we=1:
  - BRANCH: pc_write=1, pc_src=branch_taken, retired+1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=dec_mem_write & STORE.
  - On dmem_ack:
    - STORE: pc_write=1, pc_src=0, retired+1, go to FETCH.
    - LOAD: go to WB.
  - Timeout behaves as in FETCH, but with trap_cause=3.
- WB (1 cycle):
  - rf_we=dec_reg_write.
  - pc_write=1; pc_src=1 for JAL/JALR, else 0.
  - retired+1, go to FETCH.
- HALT and TRAP are absorbing until rst_n is asserted. halted/trap are set on entry and stay set.
- Acks arriving outside their waiting state are ignored.
- retired wraps modulo 2^CNT_W.
- The timeout counter is ceil(log2(MEM_TIMEOUT+1)) bits and saturates.
- Reset asserted mid-MEM or mid-FETCH drops all requests asynchronously, with no write strobe glitch, and restarts at FETCH.
- Cycles per instruction with zero-wait acks:
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4.
  - BRANCH: 3.
  - STORE: 4.
  - LOAD: 5.

Test Plan:
- OP-IMM (opcode 0010011), imem_ack immediate → state sequence 0,1,2,4,0; rf_we=1 only in WB; pc_write=1, pc_src=0 in WB; retired=1.
- LOAD with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, then WB with rf_we=1; total 8 cycles; retired=1.
- BRANCH with branch_taken=1, then =0 → EXEC pc_write=1 with pc_src=1, then pc_src=0; WB never visited; rf_we stays 0.
- Opcode 0001011 (illegal) → TRAP after DECODE, trap=1, trap_cause=1; later imem_ack is ignored; state stays 6.
- MEM_TIMEOUT=16, STORE with dmem_ack never asserted → TRAP on cycle 16 of MEM, trap_cause=3. A repeat run with ack on cycle 16 completes normally.
- rst_n pulled low while in MEM with dmem_req=1 → all outputs return to reset values immediately; after release, FETCH issues imem_req.
